piece_mover: RTL and testbench

PIECE_MOVER -- requirements
Module: piece_mover

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/piece_candidate.sv | 38 +++
 rtl/piece_mover.sv | 186 ++++++++++++++++++
 tb/tb_piece_mover.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, command codes and mover state encoding
//
// Used by piece_candidate and piece_mover.
// Command codes 5-7 are reserved. Code 4 (hard drop) is reserved as well
// unless PIECE_MOVER_HARD_DROP_EN is defined for the piece_mover build.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  // Spawn location of the 4x4 pattern window.
  localparam logic [3:0] SPAWN_X = 4'd5;
  localparam logic [4:0] SPAWN_Y = 5'd21;

  localparam logic [2:0] CMD_LEFT      = 3'd0;
  localparam logic [2:0] CMD_RIGHT     = 3'd1;
  localparam logic [2:0] CMD_DOWN      = 3'd2;
  localparam logic [2:0] CMD_ROTATE    = 3'd3;
  localparam logic [2:0] CMD_HARD_DROP = 3'd4;

  typedef enum logic [2:0] {
    ST_WAIT_SPAWN = 3'd0,
    ST_PROBE      = 3'd1,
    ST_CHECK      = 3'd2,
    ST_READY      = 3'd3,
    ST_LOCK       = 3'd4,
    ST_OVER       = 3'd5
  } mover_state_e;

  // A command that needs a collision probe. All other codes are no-ops.
  function automatic logic cmd_is_move(input logic [2:0] c, input logic hard_drop_en);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_DOWN) ||
           (c == CMD_ROTATE) || (hard_drop_en && (c == CMD_HARD_DROP));
  endfunction

endpackage

// File: rtl/piece_candidate.sv
// rtl/piece_candidate.sv - combinational candidate position/pattern for one move
//
// Ports:
//   base_x/base_y/base_float : position and pattern the move starts from
//   cmd                      : command code (see tetris_pkg)
//   rot_float                : rotated pattern supplied by the shape ROM
//   cand_x/cand_y/cand_float : resulting candidate
// Coordinates wrap modulo their width. Left from x=0 gives 4'hF, and down
// from y=0 gives 5'h1F, so that the checker rejects the move.
module piece_candidate
  import tetris_pkg::*;
(
  input  logic [3:0]  base_x,
  input  logic [4:0]  base_y,
  input  logic [15:0] base_float,
  input  logic [2:0]  cmd,
  input  logic [15:0] rot_float,
  output logic [3:0]  cand_x,
  output logic [4:0]  cand_y,
  output logic [15:0] cand_float
);

  always_comb begin
    cand_x     = base_x;
    cand_y     = base_y;
    cand_float = base_float;
    case (cmd)
      CMD_LEFT:      cand_x     = base_x - 4'd1;
      CMD_RIGHT:     cand_x     = base_x + 4'd1;
      // A hard drop step is a single-row down move.
      CMD_DOWN,
      CMD_HARD_DROP: cand_y     = base_y - 5'd1;
      CMD_ROTATE:    cand_float = rot_float;
      default: ;
    endcase
  end

endmodule

// File: rtl/piece_mover.sv
// rtl/piece_mover.sv - active piece spawn/move/lock sequencer around an external collision checker
//
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   spawn_valid, spawn_float          : new piece offer, accepted while spawn_ready
//   cmd_valid, cmd, rot_float         : move command, accepted while cmd_ready
//   chk_pos_x/chk_pos_y/chk_float     : candidate presented to the checker
//   chk_valid                         : registered checker verdict (1 = no collision)
//   cur_pos_x/cur_pos_y/cur_float     : committed piece
//   cmd_ready, spawn_ready            : handshake readiness
//   lock                              : one-cycle pulse when the piece lands
//   game_over                         : spawn collided, sticky until reset
// Optional feature macro: PIECE_MOVER_HARD_DROP_EN (cmd 4 = hard drop).
module piece_mover
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spawn_valid,
  input  logic [15:0] spawn_float,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [15:0] rot_float,
  input  logic        chk_valid,
  output logic [3:0]  chk_pos_x,
  output logic [4:0]  chk_pos_y,
  output logic [15:0] chk_float,
  output logic [3:0]  cur_pos_x,
  output logic [4:0]  cur_pos_y,
  output logic [15:0] cur_float,
  output logic        cmd_ready,
  output logic        spawn_ready,
  output logic        lock,
  output logic        game_over
);

`ifdef PIECE_MOVER_HARD_DROP_EN
  localparam logic HARD_DROP_EN = 1'b1;
`else
  localparam logic HARD_DROP_EN = 1'b0;
`endif

  mover_state_e state_q, state_d;

  logic [2:0]  op_q;        // command being probed
  logic        is_spawn_q;  // current probe is a spawn

  logic [3:0]  base_x;
  logic [4:0]  base_y;
  logic [15:0] base_float;
  logic [2:0]  base_cmd;
  logic [3:0]  cand_x;
  logic [4:0]  cand_y;
  logic [15:0] cand_float;

  logic        accept_cmd;
  logic        drop_continue;

  assign accept_cmd    = (state_q == ST_READY) && cmd_valid && cmd_is_move(cmd, HARD_DROP_EN);
  // A successful hard-drop step probes the next row straight away.
  assign drop_continue = HARD_DROP_EN && !is_spawn_q && (op_q == CMD_HARD_DROP);

  // In CHECK the next hard-drop step starts from the candidate being committed,
  // because cur_* only takes that value on the same edge.
  always_comb begin
    if (state_q == ST_CHECK) begin
      base_x     = chk_pos_x;
      base_y     = chk_pos_y;
      base_float = chk_float;
      base_cmd   = CMD_DOWN;
    end else begin
      base_x     = cur_pos_x;
      base_y     = cur_pos_y;
      base_float = cur_float;
      base_cmd   = cmd;
    end
  end

  piece_candidate u_candidate (
    .base_x     (base_x),
    .base_y     (base_y),
    .base_float (base_float),
    .cmd        (base_cmd),
    .rot_float  (rot_float),
    .cand_x     (cand_x),
    .cand_y     (cand_y),
    .cand_float (cand_float)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_SPAWN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SPAWN: if (spawn_valid) state_d = ST_PROBE;
      ST_PROBE:      state_d = ST_CHECK;
      ST_CHECK: begin
        if (is_spawn_q) begin
          state_d = chk_valid ? ST_READY : ST_OVER;
        end else if (chk_valid) begin
          state_d = drop_continue ? ST_PROBE : ST_READY;
        end else if ((op_q == CMD_DOWN) || (op_q == CMD_HARD_DROP)) begin
          state_d = ST_LOCK;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_READY:      if (accept_cmd) state_d = ST_PROBE;
      ST_LOCK:       state_d = ST_WAIT_SPAWN;
      ST_OVER:       state_d = ST_OVER;
      default:       state_d = ST_WAIT_SPAWN;
    endcase
  end

  // Output decode
  always_comb begin
    spawn_ready = 1'b0;
    cmd_ready   = 1'b0;
    lock        = 1'b0;
    game_over   = 1'b0;
    case (state_q)
      ST_WAIT_SPAWN: spawn_ready = 1'b1;
      ST_READY:      cmd_ready   = 1'b1;
      ST_LOCK:       lock        = 1'b1;
      ST_OVER:       game_over   = 1'b1;
      default: ;
    endcase
  end

  // Candidate and committed piece registers. chk_* change only on the edge
  // that enters PROBE, so they are stable through PROBE and CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_pos_x  <= '0;
      chk_pos_y  <= '0;
      chk_float  <= '0;
      cur_pos_x  <= '0;
      cur_pos_y  <= '0;
      cur_float  <= '0;
      op_q       <= '0;
      is_spawn_q <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_SPAWN: begin
          if (spawn_valid) begin
            chk_pos_x  <= SPAWN_X;
            chk_pos_y  <= SPAWN_Y;
            chk_float  <= spawn_float;
            is_spawn_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (accept_cmd) begin
            chk_pos_x  <= cand_x;
            chk_pos_y  <= cand_y;
            chk_float  <= cand_float;
            op_q       <= cmd;
            is_spawn_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (chk_valid) begin
            cur_pos_x <= chk_pos_x;
            cur_pos_y <= chk_pos_y;
            cur_float <= chk_float;
            if (drop_continue) begin
              chk_pos_x <= cand_x;
              chk_pos_y <= cand_y;
              chk_float <= cand_float;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_mover.sv
// tb/tb_piece_mover.sv - directed self-checking bench for piece_mover
module tb_piece_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spawn_valid;
  logic [15:0] spawn_float;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [15:0] rot_float;
  logic        chk_valid;
  logic [3:0]  chk_pos_x;
  logic [4:0]  chk_pos_y;
  logic [15:0] chk_float;
  logic [3:0]  cur_pos_x;
  logic [4:0]  cur_pos_y;
  logic [15:0] cur_float;
  logic        cmd_ready;
  logic        spawn_ready;
  logic        lock;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int lock_cnt = 0;

  // Board model: blocked everywhere, or open for x 0..9 and floor_y..21.
  logic       block_all;
  logic [4:0] floor_y;
  assign chk_valid = !block_all && (chk_pos_x <= 4'd9) &&
                     (chk_pos_y >= floor_y) && (chk_pos_y <= 5'd21);

  logic [3:0]  probe_x;
  logic [4:0]  probe_y;

  always #5 clk = ~clk;

  always @(negedge clk) if (lock === 1'b1) lock_cnt++;

  piece_mover dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spawn_valid (spawn_valid),
    .spawn_float (spawn_float),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .rot_float   (rot_float),
    .chk_valid   (chk_valid),
    .chk_pos_x   (chk_pos_x),
    .chk_pos_y   (chk_pos_y),
    .chk_float   (chk_float),
    .cur_pos_x   (cur_pos_x),
    .cur_pos_y   (cur_pos_y),
    .cur_float   (cur_float),
    .cmd_ready   (cmd_ready),
    .spawn_ready (spawn_ready),
    .lock        (lock),
    .game_over   (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [15:0] f);
    spawn_valid = 1'b1;
    spawn_float = f;
    tick();
    spawn_valid = 1'b0;
    tick();
    tick();
  endtask

  // Accept edge, PROBE, CHECK edge; candidate captured while in PROBE.
  task automatic do_cmd(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    probe_x   = chk_pos_x;
    probe_y   = chk_pos_y;
    tick();
    tick();
  endtask

  int saved_lock;
  int seen;
  logic [4:0] land_y;

  initial begin
    rst_n = 1'b0; spawn_valid = 1'b0; spawn_float = '0;
    cmd_valid = 1'b0; cmd = '0; rot_float = 16'h0262;
    block_all = 1'b0; floor_y = 5'd0;
    #12;
    check("rst_cur_x", 32'(cur_pos_x), 0);
    check("rst_cur_y", 32'(cur_pos_y), 0);
    check("rst_chk_f", 32'(chk_float), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_lock_over", 32'({lock, game_over}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_spawn_ready", 32'(spawn_ready), 1);

    // Spawn T; a command held during the probe must be dropped.
    spawn_valid = 1'b1;
    spawn_float = 16'h0027;
    tick();
    spawn_valid = 1'b0;
    check("spawn_chk_xy", 32'({chk_pos_x, chk_pos_y}), 32'({4'd5, 5'd21}));
    check("spawn_busy", 32'({cmd_ready, spawn_ready}), 0);
    cmd_valid = 1'b1;
    cmd = 3'd1;
    tick();
    tick();
    cmd_valid = 1'b0;
    check("spawn_ready3", 32'(cmd_ready), 1);
    check("spawn_cur", 32'({cur_pos_x, cur_pos_y, cur_float}), 32'({4'd5, 5'd21, 16'h0027}));
    tick();
    check("drop_cmd_x", 32'({cmd_ready, chk_pos_x}), 32'({1'b1, 4'd5}));

    do_cmd(3'd1);
    check("right_probe", 32'(probe_x), 6);
    check("right_cur", 32'({cmd_ready, cur_pos_x}), 32'({1'b1, 4'd6}));
    do_cmd(3'd3);
    check("rotate_cur", 32'(cur_float), 32'h0262);

    // Reserved code: accepted without leaving READY.
    cmd_valid = 1'b1; cmd = 3'd5;
    tick();
    cmd_valid = 1'b0;
    check("rsvd_ready", 32'(cmd_ready), 1);
`ifndef PIECE_MOVER_HARD_DROP_EN
    cmd_valid = 1'b1; cmd = 3'd4;
    tick();
    cmd_valid = 1'b0;
    check("hd_noop_ready", 32'({cmd_ready, cur_pos_y}), 32'({1'b1, 5'd21}));
`endif

    for (int i = 0; i < 6; i++) do_cmd(3'd0);
    check("left_to_0", 32'(cur_pos_x), 0);
    do_cmd(3'd0);
    check("left_wrap_probe", 32'(probe_x), 32'hF);
    check("left_wrap_cur", 32'({cmd_ready, cur_pos_x}), 32'({1'b1, 4'd0}));
    check("left_wrap_nolock", lock_cnt, 0);

    for (int i = 0; i < 21; i++) do_cmd(3'd2);
    check("down_to_0", 32'(cur_pos_y), 0);
    do_cmd(3'd2);
    check("down_wrap_probe", 32'(probe_y), 32'h1F);
    check("down_lock", 32'({lock, cur_pos_y}), 32'({1'b1, 5'd0}));
    tick();
    check("after_lock", 32'({lock, spawn_ready}), 32'({1'b0, 1'b1}));
    check("lock_count", lock_cnt, 1);

    // Reset in the middle of a down probe.
    do_spawn(16'h0033);
    check("spawn2_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd = 3'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_cur", 32'({cur_pos_x, cur_pos_y, cur_float}), 0);
    check("abort_chk_y", 32'(chk_pos_y), 0);
    check("abort_flags", 32'({cmd_ready, lock, game_over}), 0);
    saved_lock = lock_cnt;
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_nolock", lock_cnt, saved_lock);
    check("abort_spawn_ready", 32'(spawn_ready), 1);

`ifdef PIECE_MOVER_HARD_DROP_EN
    floor_y = 5'd3;
    do_spawn(16'h000F);
    saved_lock = lock_cnt;
    cmd_valid = 1'b1; cmd = 3'd4;
    tick();
    cmd_valid = 1'b0;
    seen = 0;
    land_y = '0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      if (cmd_ready) begin
        seen = 2;
      end else if (lock) begin
        seen = 1;
        land_y = cur_pos_y;
      end else begin
        tick();
      end
    end
    check("hd_locked", seen, 1);
    check("hd_final_y", 32'(land_y), 3);
    tick();
    check("hd_single_lock", lock_cnt, saved_lock + 1);
    floor_y = 5'd0;
`endif

    // Spawn into an occupied region ends the game.
    block_all = 1'b1;
    do_spawn(16'h0027);
    check("over_set", 32'({game_over, cmd_ready}), 32'({1'b1, 1'b0}));
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cmd_valid = 1'b1; cmd = 3'(i % 4);
      spawn_valid = 1'b1;
      block_all = i[0];
      tick();
      if (cmd_ready || spawn_ready || !game_over) seen++;
    end
    cmd_valid = 1'b0; spawn_valid = 1'b0;
    check("over_sticky", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
